pcgen_multi: RTL

- Parametrised successor to the single-redirect PC generator. Produces the fetch-address stream consumed by the IFU.
- Arbitrates NUM_REDIRECT redirect sources (channel 0 = trap, highest priority; then BRU, fence.i, etc.).
- Tags every fetch with an epoch so downstream stages discard wrong-path instructions.
- Throttles issue against a bounded count of outstanding fetches; sits between the core's redirect sources and ifu.

---
 rtl/pcgen_multi_pkg.sv | 14 +
 rtl/pcgen_multi_arb.sv | 20 ++
 rtl/pcgen_multi.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pcgen_multi_pkg.sv
// Shared fetch-path types and constants for the pcgen_multi front end.
package offnariscv_pkg;

  localparam int XLEN        = 32;
  localparam int DEF_EPOCH_W = 2;

  // Address/epoch pair as it travels from the PC generator to the IFU
  // (for the default epoch width).
  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [DEF_EPOCH_W-1:0] epoch;
  } fetch_req_t;

endpackage

// File: rtl/pcgen_multi_arb.sv
// N-way fixed-priority arbiter: lowest-index request wins, one-hot grant.
module prio_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  // Scan from the top down so the lowest-index requester overwrites the rest.
  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcgen_multi.sv
// Multi-source PC generator: arbitrates redirects, tags fetches with an
// epoch and throttles issue against a bounded number of outstanding fetches.
module pcgen_multi
  import offnariscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              NUM_REDIRECT = 2,
  parameter int              FETCH_BYTES  = 4,
  parameter int              EPOCH_W      = DEF_EPOCH_W,
  parameter int              MAX_INFLIGHT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REDIRECT-1:0]      redirect_tvalid,
  input  logic [NUM_REDIRECT*XLEN-1:0] redirect_tdata,
  output logic [NUM_REDIRECT-1:0]      redirect_tready,
  output logic                         next_pc_tvalid,
  input  logic                         next_pc_tready,
  output logic [XLEN-1:0]              next_pc_tdata,
  output logic [EPOCH_W-1:0]           next_pc_tuser,
  input  logic                         fetch_resp,
  output logic [EPOCH_W-1:0]           epoch,
  output logic                         invalidate
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  // Redirect targets only need to be instruction-aligned.
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

  // Sequential step: snap to the fetch beat and advance one beat (wraps).
  function automatic logic [XLEN-1:0] incr(input logic [XLEN-1:0] a);
    return (a & ~XLEN'(FETCH_BYTES - 1)) + XLEN'(FETCH_BYTES);
  endfunction

  logic [NUM_REDIRECT-1:0] req;
  logic [NUM_REDIRECT-1:0] gnt;
  logic [XLEN-1:0]         target;
  logic                    redir;
  logic [XLEN-1:0]         pc_sel;
  logic [EPOCH_W-1:0]      epoch_n;
  logic                    hs;
  logic [IW:0]             infl_pre;
  logic                    load;

  // p0: next address to issue
  logic [XLEN-1:0]         pc_p0;
  // p1: output slot presented to the IFU
  logic                    vld_p1;
  logic [XLEN-1:0]         addr_p1;
  logic [EPOCH_W-1:0]      ep_p1;
  // control state
  logic [EPOCH_W-1:0]      epoch_r;
  logic [IW-1:0]           infl_r;
  logic                    inv_r;

  // No grants are handed out while in reset.
  assign req = redirect_tvalid & {NUM_REDIRECT{~rst}};

  prio_arbiter #(.N(NUM_REDIRECT)) u_arb (
    .req (req),
    .gnt (gnt)
  );

  assign redirect_tready = gnt;
  assign redir           = |gnt;

  // Select the winning channel's target; the grant is one-hot so OR-ing is safe.
  always_comb begin
    target = '0;
    for (int i = 0; i < NUM_REDIRECT; i++) begin
      if (gnt[i]) target = target | redirect_tdata[i*XLEN +: XLEN];
    end
  end

  assign pc_sel  = redir ? align_target(target) : pc_p0;
  assign epoch_n = redir ? epoch_r + EPOCH_W'(1) : epoch_r;
  assign hs      = vld_p1 & next_pc_tready;

  // Projected outstanding count; a stray response at zero is ignored.
  always_comb begin
    infl_pre = {1'b0, infl_r} + (IW+1)'(hs);
    if (fetch_resp && (infl_pre != '0)) infl_pre = infl_pre - (IW+1)'(1);
  end

  assign load = (!vld_p1 || hs) && (infl_pre < (IW+1)'(MAX_INFLIGHT));

  // PC, output slot, epoch, credit counter and invalidate pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0   <= RESET_VECTOR;
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      ep_p1   <= '0;
      epoch_r <= '0;
      infl_r  <= '0;
      inv_r   <= 1'b0;
    end else begin
      epoch_r <= epoch_n;
      infl_r  <= infl_pre[IW-1:0];
      inv_r   <= redir;
      if (load) begin
        vld_p1  <= 1'b1;
        addr_p1 <= pc_sel;
        ep_p1   <= epoch_n;
        pc_p0   <= incr(pc_sel);
      end else begin
        // A stalled beat keeps its address and epoch; redirects land in pc.
        pc_p0 <= pc_sel;
        if (hs) vld_p1 <= 1'b0;
      end
    end
  end

  assign next_pc_tvalid = vld_p1;
  assign next_pc_tdata  = addr_p1;
  assign next_pc_tuser  = ep_p1;
  assign epoch          = epoch_r;
  assign invalidate     = inv_r;

  // A response can only retire a fetch that was actually issued.
  a_no_resp_underflow: assert property (@(posedge clk) disable iff (rst)
    !(fetch_resp && (infl_r == '0)));

endmodule
